// File: rtl/nn_pkg.sv
// Shared sizes, FSM encoding and the hard-wired weight table for the single-neuron engine.
package nn_pkg;

  localparam int N_IN  = 16;
  localparam int ACC_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    FINISH
  } state_t;

  // Weight table entry: 8-bit wrap of 17*n + 3*i + 1, interpreted as signed.
  function automatic logic signed [7:0] weight(input logic [2:0] n, input logic [3:0] i);
    logic [7:0] t;
    t = 8'd17 * {5'd0, n} + 8'd3 * {4'd0, i} + 8'd1;
    return t;
  endfunction

endpackage

// File: rtl/nn_mac.sv
// Combinational unsigned-x-signed 8x8 multiply-accumulate stage, kept as its own
// block so the multiplier shows up isolated in power traces.
module nn_mac
  import nn_pkg::*;
(
  input  logic        [7:0]       x,
  input  logic signed [7:0]       w,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [ACC_W-1:0] acc_out
);

  logic signed [16:0] x_ext;
  logic signed [16:0] w_ext;
  logic signed [16:0] prod;

  // Product of a 9-bit positive and an 8-bit signed value always fits in 17 bits.
  assign x_ext   = {9'd0, x};
  assign w_ext   = {{9{w[7]}}, w};
  assign prod    = x_ext * w_ext;
  assign acc_out = acc_in + {{(ACC_W-17){prod[16]}}, prod};

endmodule

// File: rtl/neural_network.sv
// Single-neuron inference: collect 16 bytes, run 16 MAC cycles with a selectable
// weight set and optional ReLU, flag the compute window on trigOut.
module neural_network
  import nn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             byteRecv,
  input  logic [7:0]       byteIn,
  input  logic [3:0]       sw,
  output logic             trigOut,
  output logic [4:0]       byteCnt,
  output logic [ACC_W-1:0] dataOut
);

  localparam logic [4:0] LAST_BYTE = 5'(N_IN - 1);
  localparam logic [3:0] LAST_IDX  = 4'(N_IN - 1);

  state_t                  state;
  logic [7:0]              x [N_IN];
  logic [3:0]              idx;
  logic [3:0]              sw_q;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] mac_sum;

  nn_mac u_mac (
    .x      (x[idx]),
    .w      (weight(sw_q[2:0], idx)),
    .acc_in (acc),
    .acc_out(mac_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      byteCnt <= '0;
      trigOut <= 1'b0;
      dataOut <= '0;
      idx     <= '0;
      sw_q    <= '0;
      acc     <= '0;
      for (int i = 0; i < N_IN; i++) x[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (byteRecv) begin
            x[byteCnt[3:0]] <= byteIn;
            byteCnt         <= byteCnt + 5'd1;
            if (byteCnt == LAST_BYTE) begin
              sw_q    <= sw;
              acc     <= '0;
              idx     <= '0;
              state   <= COMPUTE;
              trigOut <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          acc <= mac_sum;
          idx <= idx + 4'd1;
          if (idx == LAST_IDX) begin
            state   <= FINISH;
            trigOut <= 1'b0;
          end
        end
        FINISH: begin
          // ReLU clamps only negative sums; byteCnt reopens for the next frame.
          dataOut <= (sw_q[3] && acc[ACC_W-1]) ? '0 : acc;
          byteCnt <= '0;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          trigOut <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neural_network.sv
// Bench for neural_network: directed and random frames checked against an arithmetic
// model of the weighted sum, plus asynchronous reset and byte-drop behaviour.
module tb_neural_network;

  logic        clk = 1'b0;
  logic        rst;
  logic        byteRecv;
  logic [7:0]  byteIn;
  logic [3:0]  sw;
  logic        trigOut;
  logic [4:0]  byteCnt;
  logic [23:0] dataOut;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  xs [16];
  logic [23:0] last_result;

  neural_network dut (
    .clk     (clk),
    .rst     (rst),
    .byteRecv(byteRecv),
    .byteIn  (byteIn),
    .sw      (sw),
    .trigOut (trigOut),
    .byteCnt (byteCnt),
    .dataOut (dataOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain dot product of unsigned bytes with the wrapped signed weights.
  function automatic int ref_result(input logic [3:0] s);
    int sum, w;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      w = (17 * int'(s[2:0]) + 3 * i + 1) % 256;
      if (w > 127) w -= 256;
      sum += int'({24'd0, xs[i]}) * w;
    end
    if (s[3] && sum < 0) sum = 0;
    return sum;
  endfunction

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      byteRecv = 1'b1;
      byteIn   = xs[i];
      @(posedge clk);
      #1;
      check("byte_cnt", {27'd0, byteCnt}, 32'(i + 1));
    end
    byteRecv = 1'b0;
  endtask

  task automatic run_inf(input logic [3:0] s, input bit ignore_test);
    int          trig_cnt;
    logic [23:0] exp;
    exp = 24'(ref_result(s));
    sw  = s;
    send_bytes(16);
    sw = 4'($urandom);
    check("trig_start", {31'd0, trigOut}, 32'd1);
    trig_cnt = 1;
    for (int k = 0; k < 17; k++) begin
      byteRecv = ignore_test && (k == 3 || k == 4 || k == 16);
      byteIn   = 8'($urandom);
      @(posedge clk);
      #1;
      if (trigOut) trig_cnt++;
      if (k == 15) begin
        check("byte_cnt_hold", {27'd0, byteCnt}, 32'd16);
        check("data_hold", {8'd0, dataOut}, {8'd0, last_result});
      end
    end
    byteRecv = 1'b0;
    check("trig_len", 32'(trig_cnt), 32'd16);
    check("data_out", {8'd0, dataOut}, {8'd0, exp});
    check("byte_cnt_clr", {27'd0, byteCnt}, 32'd0);
    last_result = exp;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_trig", {31'd0, trigOut}, 32'd0);
    check("rst_cnt", {27'd0, byteCnt}, 32'd0);
    check("rst_data", {8'd0, dataOut}, 32'd0);
    last_result = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    byteRecv    = 1'b0;
    byteIn      = '0;
    sw          = '0;
    last_result = '0;
    #12;
    check("reset_trig", {31'd0, trigOut}, 32'd0);
    check("reset_cnt", {27'd0, byteCnt}, 32'd0);
    check("reset_data", {8'd0, dataOut}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    xs = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22,
           8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'h15};
    run_inf(4'h0, 1'b0);
    check("stream_const", {8'd0, dataOut}, 32'h0000_9A2F);

    for (int i = 0; i < 16; i++) xs[i] = 8'hFF;
    run_inf(4'h7, 1'b1);
    check("negative_const", {8'd0, dataOut}, 32'h00FB_EC18);
    run_inf(4'hF, 1'b0);
    check("relu_const", {8'd0, dataOut}, 32'h0000_0000);

    // Reset in the middle of a compute window.
    run_inf(4'h7, 1'b0);
    send_bytes(16);
    repeat (5) @(posedge clk);
    pulse_reset();

    // Abort after a partial frame, then a full frame must start from byte 0.
    for (int i = 0; i < 16; i++) xs[i] = 8'($urandom);
    send_bytes(8);
    pulse_reset();
    for (int i = 0; i < 16; i++) xs[i] = 8'h01;
    run_inf(4'h0, 1'b0);
    check("abort_const", {8'd0, dataOut}, 32'h0000_0178);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) xs[i] = 8'($urandom);
      run_inf(4'($urandom), r[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
